// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory target for the MEM stage: accept, WAIT_CYCLES wait states, one-cycle response.
// Optional address fault checking is enabled by defining DMEM_ERR_CHECK_EN.
module data_mem_responder #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ready_o,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              bad_q, bad_d;
  logic              ready_q, ready_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  logic              accept_c;
  logic              req_bad_c;
  logic [IDX_W-1:0]  req_idx_c;
  logic              enter_c;
  logic              we_c;
  logic              sel_rd_c;
  logic              sel_wr_c;
  logic              sel_bad_c;
  logic [IDX_W-1:0]  sel_idx_c;
  logic [DATA_W-1:0] sel_wdata_c;

  assign accept_c  = (state_q == ST_IDLE) && (mem_read_i || mem_write_i);
  assign req_idx_c = addr_i[IDX_W+1:2];

`ifdef DMEM_ERR_CHECK_EN
  assign req_bad_c = (mem_read_i && mem_write_i) ||
                     (addr_i[1:0] != 2'b00) ||
                     (addr_i >= ADDR_W'(4 * DEPTH_WORDS));
`else
  // Byte offset and bits above the index field are don't-care: the index wraps.
  logic unused_addr;
  assign unused_addr = ^{addr_i[ADDR_W-1:IDX_W+2], addr_i[1:0]};
  assign req_bad_c   = mem_read_i && mem_write_i;
`endif

  // Next-state, request latch and response formation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    bad_d       = bad_q;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    rdata_d     = '0;
    we_c        = 1'b0;
    enter_c     = 1'b0;
    sel_rd_c    = rd_q;
    sel_wr_c    = wr_q;
    sel_bad_c   = bad_q;
    sel_idx_c   = idx_q;
    sel_wdata_c = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          idx_d   = req_idx_c;
          wdata_d = wdata_i;
          rd_d    = mem_read_i;
          wr_d    = mem_write_i;
          bad_d   = req_bad_c;
          if (WAIT_CYCLES == 0) begin
            // No wait states: respond straight from the incoming request.
            state_d     = ST_RESP;
            enter_c     = 1'b1;
            sel_rd_c    = mem_read_i;
            sel_wr_c    = mem_write_i;
            sel_bad_c   = req_bad_c;
            sel_idx_c   = req_idx_c;
            sel_wdata_c = wdata_i;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          enter_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_c) begin
      rvalid_d = 1'b1;
      if (sel_bad_c) begin
        err_d = 1'b1;
      end else if (sel_rd_c) begin
        rdata_d = mem_q[sel_idx_c];
      end else if (sel_wr_c) begin
        we_c = !rst_i;
      end
    end

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      bad_q    <= 1'b0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      bad_q    <= bad_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is deliberately not reset; the store commits on the edge entering RESP.
  always_ff @(posedge clk_i) begin
    if (we_c) begin
      mem_q[sel_idx_c] <= sel_wdata_c;
    end
  end

  assign ready_o  = ready_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule
